// File: rtl/lfu_replace_ctrl_if.sv
// lfu_replace_ctrl_if
// Request/response bundle for the LFU replacement controller.
//   req_valid/req_ready : request handshake (accepted when both high)
//   req_set             : target set index
//   req_hit             : 1 = hit on req_way, 0 = miss (victim wanted)
//   req_inv             : 1 = invalidate req_way (overrides req_hit)
//   req_way             : hit/invalidate way, ignored on a miss
//   rsp_valid           : one-cycle pulse, update complete
//   rsp_way             : way that was updated (held between pulses)
//   rsp_aged            : set was halved during this operation (held)
// master drives requests, slave is the controller.
interface lfu_replace_ctrl_if #(
    parameter int SETS = 4
);
    localparam int SW = (SETS > 1) ? $clog2(SETS) : 1;

    logic          req_valid;
    logic          req_ready;
    logic [SW-1:0] req_set;
    logic          req_hit;
    logic          req_inv;
    logic [1:0]    req_way;
    logic          rsp_valid;
    logic [1:0]    rsp_way;
    logic          rsp_aged;

    modport master (
        output req_valid, req_set, req_hit, req_inv, req_way,
        input  req_ready, rsp_valid, rsp_way, rsp_aged
    );

    modport slave (
        input  req_valid, req_set, req_hit, req_inv, req_way,
        output req_ready, rsp_valid, rsp_way, rsp_aged
    );
endinterface

// File: rtl/lfu_replace_ctrl.sv
// lfu_replace_ctrl
// Least-frequently-used replacement controller for SETS x 4-way sets.
// Each way has a saturating-by-aging W-bit use counter. Hits increment,
// misses pick the lowest-count way (lowest index on ties) and set it to 1,
// invalidates clear it. A hit on a saturated counter halves the whole set
// and then bumps the target.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : lfu_replace_ctrl_if slave modport (request/response bundle)
module lfu_replace_ctrl #(
    parameter int W    = 4,
    parameter int SETS = 4
) (
    input  logic                clk,
    input  logic                rst,
    lfu_replace_ctrl_if.slave   bus
);
    localparam int SW = (SETS > 1) ? $clog2(SETS) : 1;
    localparam logic [W-1:0] CNT_MAX = '1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOOKUP = 2'd1;
    localparam logic [1:0] UPDATE = 2'd2;
    localparam logic [1:0] AGE    = 2'd3;

    logic [1:0]    state;
    logic [SW-1:0] set_q;
    logic          hit_q;
    logic          inv_q;
    logic [1:0]    way_q;
    logic [1:0]    tgt_q;
    logic [1:0]    rsp_way_q;
    logic          rsp_aged_q;

    logic [W-1:0]  cnt [SETS][4];
    logic [W-1:0]  set_cnt [4];
    logic [W-1:0]  min_cnt;
    logic [1:0]    victim;
    logic          upd_sat;
    logic          rsp_fire;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            set_cnt[i] = cnt[set_q][i];
        end
    end

    // Strict less-than keeps the earliest way on ties.
    always_comb begin
        victim  = 2'd0;
        min_cnt = set_cnt[0];
        for (int i = 1; i < 4; i++) begin
            if (set_cnt[i] < min_cnt) begin
                victim  = 2'(i);
                min_cnt = set_cnt[i];
            end
        end
    end

    // A hit on a saturated counter skips the response and goes to aging.
    always_comb begin
        upd_sat  = hit_q && !inv_q && (set_cnt[tgt_q] == CNT_MAX);
        rsp_fire = !rst && (((state == UPDATE) && !upd_sat) || (state == AGE));
    end

    // Response fields show the live result during the pulse, then hold.
    always_comb begin
        bus.req_ready = (state == IDLE) && !rst;
        bus.rsp_valid = rsp_fire;
        bus.rsp_way   = rsp_fire ? tgt_q : rsp_way_q;
        bus.rsp_aged  = rsp_fire ? (state == AGE) : rsp_aged_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            set_q      <= '0;
            hit_q      <= 1'b0;
            inv_q      <= 1'b0;
            way_q      <= 2'd0;
            tgt_q      <= 2'd0;
            rsp_way_q  <= 2'd0;
            rsp_aged_q <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < 4; w++) begin
                    cnt[s][w] <= '0;
                end
            end
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        set_q <= bus.req_set;
                        hit_q <= bus.req_hit;
                        inv_q <= bus.req_inv;
                        way_q <= bus.req_way;
                        state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    tgt_q <= (inv_q || hit_q) ? way_q : victim;
                    state <= UPDATE;
                end
                UPDATE: begin
                    if (inv_q) begin
                        cnt[set_q][tgt_q] <= '0;
                    end else if (!hit_q) begin
                        cnt[set_q][tgt_q] <= W'(1);
                    end else if (!upd_sat) begin
                        cnt[set_q][tgt_q] <= set_cnt[tgt_q] + 1'b1;
                    end
                    state <= upd_sat ? AGE : IDLE;
                end
                AGE: begin
                    // Halve the whole set and credit the target in one write.
                    for (int w = 0; w < 4; w++) begin
                        if (2'(w) == tgt_q) begin
                            cnt[set_q][w] <= (set_cnt[w] >> 1) + 1'b1;
                        end else begin
                            cnt[set_q][w] <= set_cnt[w] >> 1;
                        end
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (rsp_fire) begin
                rsp_way_q  <= tgt_q;
                rsp_aged_q <= (state == AGE);
            end
        end
    end
endmodule

// File: doc/lfu_replace_ctrl.md
LFU_REPLACE_CTRL -- requirements
Module: lfu_replace_ctrl

Interface
REQ-001 SHALL have parameter W, default 4: width of each per-way use counter.
REQ-002 SHALL have parameter SETS, default 4: number of 4-way sets tracked; SW = $clog2(SETS).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  access request present.
REQ-006 SHALL have port req_ready  output  1  controller can accept a request.
REQ-007 SHALL have port req_set  input  SW  target set index.
REQ-008 SHALL have port req_hit  input  1  1 = cache hit on req_way; 0 = miss, victim required.
REQ-009 SHALL have port req_inv  input  1  1 = invalidate req_way; takes priority over req_hit.
REQ-010 SHALL have port req_way  input  2  hit or invalidate way; ignored on a miss.
REQ-011 SHALL have port rsp_valid  output  1  one-cycle pulse: update done, rsp_way valid.
REQ-012 SHALL have port rsp_way  output  2  way updated: hit way, invalidated way or chosen victim.
REQ-013 SHALL have port rsp_aged  output  1  set was aged (halved) during this operation; qualified by rsp_valid.

Function
REQ-014 SHALL hold SETS x 4 unsigned W-bit counters; one request in flight at a time.
REQ-015 SHALL implement FSM states IDLE, LOOKUP, UPDATE, AGE.
REQ-016 req_ready SHALL be 1 only in IDLE with rst low; a request is accepted on a cycle with req_valid and req_ready both 1, and req_set/req_hit/req_inv/req_way are captured into registers at that edge.
REQ-017 IDLE -> LOOKUP on acceptance; otherwise remain in IDLE.
REQ-018 LOOKUP SHALL read the four counters of the captured set and select target: req_way if inv or hit; otherwise victim = way with minimum count, ties resolved to lowest way index; always -> UPDATE.
REQ-019 UPDATE, inv: target counter := 0; rsp_valid=1, rsp_aged=0; -> IDLE.
REQ-020 UPDATE, miss: victim counter := 1; rsp_valid=1, rsp_aged=0; -> IDLE.
REQ-021 UPDATE, hit with target counter < 2^W-1: target counter := counter+1; rsp_valid=1, rsp_aged=0; -> IDLE.
REQ-022 UPDATE, hit with target counter = 2^W-1: no write, no rsp; -> AGE.
REQ-023 AGE SHALL right-shift all four counters of the set by 1, then set target := (old target >> 1) + 1, in a single write; rsp_valid=1, rsp_aged=1; -> IDLE.
REQ-024 Latency: rsp_valid SHALL assert 2 cycles after the accept edge (3 when aging); next accept possible in the cycle after rsp_valid.
REQ-025 Counters SHALL never wrap; only the target set's counters change in any operation.
REQ-026 rsp_way/rsp_aged SHALL hold their last values between pulses.
REQ-027 Counter writes SHALL occur only at the edge ending the UPDATE or AGE cycle in which rsp_valid is high.

Reset
REQ-028 While rst=1 at a clock edge: FSM := IDLE, all counters := 0, rsp_valid := 0, rsp_way := 0, rsp_aged := 0; req_ready SHALL be 0 while rst=1.
REQ-029 rst asserted in LOOKUP, UPDATE or AGE SHALL abort the operation: no counter write, no rsp_valid pulse.
REQ-030 req_ready SHALL be 1 in the first cycle rst is low.

Verification
REQ-031 Reset, then miss on set 0 -> rsp_valid 2 cycles after accept, rsp_way=0, set 0 counters {1,0,0,0}; repeat miss -> rsp_way=1, counters {1,1,0,0}.
REQ-032 Set 1 preloaded via hits to {3,5,7,15}; hit way 3 -> rsp_valid 3 cycles after accept, rsp_aged=1, counters {1,2,3,8}.
REQ-033 Set 2 {4,2,2,6}, hit way 0 -> {5,2,2,6}, rsp_aged=0; miss -> rsp_way=1 (tie, lowest index), counters {5,1,2,6}; sets 0, 1, 3 unchanged.
REQ-034 Set 3 {2,3,4,5}, req_inv=1 with req_hit=1 on way 2 -> counters {2,3,0,5}, rsp_way=2; then miss -> rsp_way=2, counters {2,3,1,5}.
REQ-035 rst raised in the LOOKUP cycle of a set-0 hit -> no rsp_valid pulse, all counters 0, req_ready=1 in the first cycle after rst falls.
REQ-036 req_valid held high continuously -> req_ready low from accept edge through the rsp_valid cycle, and exactly one rsp_valid per accepted request.
